// File: rtl/uart_tx.sv
// UART transmit engine: start, LSB-first data, optional even parity, stop bits.
// CTS gates the start of a frame only; Tx is a registered output.
module uart_tx #(
    parameter int SYSCLK_RATE = 100000000,
    parameter int BAUD_RATE   = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_BIT  = 1,
    parameter int STOP_BITS   = 2
) (
    input  logic                 SysClk,
    input  logic                 Rst,
    input  logic [DATA_BITS-1:0] Tx_Data,
    input  logic                 Transmit_Start,
    input  logic                 CTS,
    output logic                 Tx,
    output logic                 Tx_Busy,
    output logic                 Tx_Done
);

    localparam int CLKS_PER_BIT = SYSCLK_RATE / BAUD_RATE;
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WAIT   = 3'd1;
    localparam logic [2:0] S_START  = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_PARITY = 3'd4;
    localparam logic [2:0] S_STOP   = 3'd5;

    logic [2:0]           state;
    logic [BW-1:0]        baud_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 parity;
    logic                 start_prev;
    logic                 baud_end;
    logic                 accept;

    assign baud_end = (baud_cnt == BAUD_LAST);
    assign accept   = (state == S_IDLE) && Transmit_Start && !start_prev;

    // Remember last request level so only a fresh 0->1 edge launches a frame.
    always_ff @(posedge SysClk) begin
        if (Rst) begin
            start_prev <= 1'b1;
        end else begin
            start_prev <= Transmit_Start;
        end
    end

    // Frame sequencer: drives Tx one cycle ahead from the registered state.
    always_ff @(posedge SysClk) begin
        if (Rst) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            parity    <= 1'b0;
            Tx        <= 1'b1;
            Tx_Busy   <= 1'b0;
            Tx_Done   <= 1'b0;
        end else begin
            Tx_Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    Tx <= 1'b1;
                    if (accept) begin
                        shift_reg <= Tx_Data;
                        parity    <= ^Tx_Data;
                        Tx_Busy   <= 1'b1;
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                        if (CTS) begin
                            state <= S_START;
                            Tx    <= 1'b0;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (CTS) begin
                        state    <= S_START;
                        Tx       <= 1'b0;
                        baud_cnt <= '0;
                    end
                end
                S_START: begin
                    if (baud_end) begin
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                        state     <= S_DATA;
                        Tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_BIT != 0) begin
                                state <= S_PARITY;
                                Tx    <= parity;
                            end else begin
                                state <= S_STOP;
                                Tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 4'd1;
                            Tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_PARITY: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= '0;
                        state    <= S_STOP;
                        Tx       <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                S_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= S_IDLE;
                            Tx      <= 1'b1;
                            Tx_Busy <= 1'b0;
                            Tx_Done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BW'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    Tx      <= 1'b1;
                    Tx_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
